// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption: one inverse round per cycle, NR cycles from the accept edge to out_valid; the result is held in DONE while out_ready=0.
// Optional AES_INV_ZEROIZE_EN: out_data reads 0 unless out_valid, and the state register clears on the output handshake.

module inv_shift_rows (
  input  logic [127:0] d,
  output logic [127:0] q
);
  // Byte (row r, col c) sits at index 4c+r; row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign q[127-8*(4*c+r) -: 8] = d[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end
endmodule

module inv_sub_bytes (
  input  logic [127:0] d,
  output logic [127:0] q
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Undo the affine map, then take the GF(2^8) inverse as a^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] sq;
    logic [7:0] acc;
    a   = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign q[127-8*i -: 8] = inv_sbox(d[127-8*i -: 8]);
  end
endmodule

module inv_mix_columns (
  input  logic [127:0] d,
  output logic [127:0] q
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign q[127-32*c -: 32] = mix_col(d[127-32*c -: 32]);
  end
endmodule

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX  = 4'(NR);
  localparam logic [3:0] NR_LAST = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] sreg, sreg_nxt;
  logic [127:0] isr, isb, t, imc;

  inv_shift_rows  u_isr (.d(sreg), .q(isr));
  inv_sub_bytes   u_isb (.d(isr),  .q(isb));
  assign t = isb ^ rk_data;
  inv_mix_columns u_imc (.d(t),    .q(imc));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= IDLE;
      rnd  <= NR_IDX;
      sreg <= '0;
    end else begin
      st   <= st_nxt;
      rnd  <= rnd_nxt;
      sreg <= sreg_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    rnd_nxt  = rnd;
    sreg_nxt = sreg;
    case (st)
      IDLE: begin
        if (in_valid) begin
          sreg_nxt = in_data ^ rk_data;
          rnd_nxt  = NR_LAST;
          st_nxt   = ROUND;
        end
      end
      ROUND: begin
        // The last round (r == 0) skips InvMixColumns.
        if (rnd != 4'd0) begin
          sreg_nxt = imc;
          rnd_nxt  = rnd - 4'd1;
        end else begin
          sreg_nxt = t;
          st_nxt   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          st_nxt  = IDLE;
          rnd_nxt = NR_IDX;
`ifdef AES_INV_ZEROIZE_EN
          sreg_nxt = '0;
`endif
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
    case (st)
      IDLE:    rk_idx = NR_IDX;
      ROUND:   rk_idx = rnd;
      default: rk_idx = 4'd0;
    endcase
`ifdef AES_INV_ZEROIZE_EN
    out_data = out_valid ? sreg : '0;
`else
    out_data = sreg;
`endif
  end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench: forward AES reference model encrypts random plaintexts; a queue scoreboard checks what the decryptor returns.
module tb_aes_inv_cipher_iter;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [127:0] a_in_data, a_rk_data, a_out_data;
  logic [3:0]   a_rk_idx;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [127:0] b_in_data, b_rk_data, b_out_data;
  logic [3:0]   b_rk_idx;
  logic [1919:0] rka, rkb;

  assign a_rk_data = rka[int'(a_rk_idx)*128 +: 128];
  assign b_rk_data = rkb[int'(b_rk_idx)*128 +: 128];

  aes_inv_cipher_iter #(.NR(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .rk_idx(a_rk_idx), .rk_data(a_rk_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data));

  aes_inv_cipher_iter #(.NR(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .rk_idx(b_rk_idx), .rk_data(b_rk_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] sbox [256];

  typedef struct { logic [127:0] pt; int due; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   rise_a[$];
  logic pva = 1'b0;
  logic pvb = 1'b0;
  bit   rnd_phase;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  // ---------------- reference model (forward cipher) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] res;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subword(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] rk, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] k;
    logic [127:0] res;
    k = rk[127:0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) u[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        if (rd != nr) begin
          s[4*c]   = gmul(8'h02, u[4*c]) ^ gmul(8'h03, u[4*c+1]) ^ u[4*c+2] ^ u[4*c+3];
          s[4*c+1] = u[4*c] ^ gmul(8'h02, u[4*c+1]) ^ gmul(8'h03, u[4*c+2]) ^ u[4*c+3];
          s[4*c+2] = u[4*c] ^ u[4*c+1] ^ gmul(8'h02, u[4*c+2]) ^ gmul(8'h03, u[4*c+3]);
          s[4*c+3] = gmul(8'h03, u[4*c]) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(8'h02, u[4*c+3]);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c+row] = u[4*c+row];
        end
      end
      k = rk[rd*128 +: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_out_valid && !pva) begin
        rise_a.push_back(cyc);
        if (qa.size() == 0) fail_now("a_spurious_valid");
        else check("a_latency", 128'(cyc), 128'(qa[0].due));
      end
      if (a_out_valid && a_out_ready && qa.size() != 0) begin
        e = qa.pop_front();
        check("a_data", a_out_data, e.pt);
      end
    end
    pva <= a_out_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b_out_valid && !pvb) begin
        if (qb.size() == 0) fail_now("b_spurious_valid");
        else check("b_latency", 128'(cyc), 128'(qb[0].due));
      end
      if (b_out_valid && b_out_ready && qb.size() != 0) begin
        e = qb.pop_front();
        check("b_data", b_out_data, e.pt);
      end
    end
    pvb <= b_out_valid;
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit use_b, input logic [127:0] ct, input logic [127:0] pt, output int acc);
    int   n;
    exp_t e;
    @(posedge clk);
    #1;
    if (use_b) begin b_in_valid = 1'b1; b_in_data = ct; end
    else       begin a_in_valid = 1'b1; a_in_data = ct; end
    n = 0;
    @(negedge clk);
    while (!(use_b ? b_in_ready : a_in_ready) && n < 100) begin
      n++;
      @(negedge clk);
    end
    acc = cyc + 1;
    if (!(use_b ? b_in_ready : a_in_ready)) begin
      fail_now(use_b ? "b_accept" : "a_accept");
    end else begin
      e.pt  = pt;
      e.due = acc + (use_b ? 14 : 10);
      if (use_b) qb.push_back(e);
      else       qa.push_back(e);
    end
    @(posedge clk);
    #1;
    if (use_b) b_in_valid = 1'b0;
    else       a_in_valid = 1'b0;
  endtask

  task automatic wait_empty(input bit use_b, input int budget);
    int n = 0;
    while (((use_b ? qb.size() : qa.size()) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((use_b ? qb.size() : qa.size()) != 0) begin
      fail_now(use_b ? "b_drain" : "a_drain");
      if (use_b) qb.delete();
      else       qa.delete();
    end
  endtask

  initial begin
    int acc, acc2;
    logic [127:0] pt, ct;
    logic [7:0]   inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    rka = expand(KEY128, 4, 10);
    rkb = expand(KEY256, 8, 14);

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  128'(a_in_ready), 128'(1));
    check("rst_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_out_data",  a_out_data, 128'(0));
    check("rst_rk_idx",    128'(a_rk_idx), 128'(10));
    check("rst_rk_idx_b",  128'(b_rk_idx), 128'(14));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // C.1 under backpressure
    a_out_ready = 1'b0;
    send(1'b0, C1_CT, PT, acc);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("round_rk_idx", 128'(a_rk_idx), 128'(10 - k));
`ifdef AES_INV_ZEROIZE_EN
      check("round_data_hidden", a_out_data, 128'(0));
`else
      check("round_data_visible", 128'(a_out_data != 128'(0)), 128'(1));
`endif
    end
    @(negedge clk);
    check("c1_valid", 128'(a_out_valid), 128'(1));
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      a_in_valid = 1'b1;
      a_in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      check("bp_hold_data", a_out_data, PT);
      check("bp_in_ready",  128'(a_in_ready), 128'(0));
      check("bp_valid",     128'(a_out_valid), 128'(1));
    end
    @(posedge clk);
    #1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_in_ready", 128'(a_in_ready), 128'(1));
    check("post_hs_valid",    128'(a_out_valid), 128'(0));
    check("post_hs_rk_idx",   128'(a_rk_idx), 128'(10));
`ifdef AES_INV_ZEROIZE_EN
    check("post_hs_data", a_out_data, 128'(0));
`else
    check("post_hs_data", a_out_data, PT);
`endif

    // back-to-back
    rise_a.delete();
    send(1'b0, C1_CT, PT, acc);
    send(1'b0, C1_CT, PT, acc2);
    check("b2b_accept_gap", 128'(acc2 - acc), 128'(12));
    wait_empty(1'b0, 100);
    if (rise_a.size() == 2) check("b2b_output_gap", 128'(rise_a[1] - rise_a[0]), 128'(12));
    else fail_now("b2b_output_count");

    // reset during the 4th ROUND cycle
    send(1'b0, C1_CT, PT, acc);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    qa.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid",    128'(a_out_valid), 128'(0));
    check("midrst_data",     a_out_data, 128'(0));
    check("midrst_in_ready", 128'(a_in_ready), 128'(1));
    check("midrst_rk_idx",   128'(a_rk_idx), 128'(10));
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(1'b0, C1_CT, PT, acc);
    wait_empty(1'b0, 100);

    // NR=14, FIPS-197 C.3
    send(1'b1, C3_CT, PT, acc);
    wait_empty(1'b1, 100);

    // random keys and plaintexts with random out_ready
    rnd_phase = 1'b1;
    fork
      begin
        for (int blk = 0; blk < 4; blk++) begin
          wait_empty(1'b0, 300);
          rka = expand({$urandom(), $urandom(), $urandom(), $urandom(), 128'h0}, 4, 10);
          for (int i = 0; i < 5; i++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct = encrypt(pt, rka, 10);
            send(1'b0, ct, pt, acc);
          end
        end
        wait_empty(1'b0, 300);
        rnd_phase = 1'b0;
      end
      begin
        while (rnd_phase) begin
          @(posedge clk);
          #1 a_out_ready = 1'($urandom_range(0, 1));
        end
        a_out_ready = 1'b1;
      end
    join

    for (int blk = 0; blk < 3; blk++) begin
      rkb = expand({$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()}, 8, 14);
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct = encrypt(pt, rkb, 14);
      send(1'b1, ct, pt, acc);
      wait_empty(1'b1, 100);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
